// File: rtl/line_backing_memory.sv
// Fixed-latency 256-bit line memory behind a three-state request/ack handshake.
// Optional protocol checker (err_o) is enabled by defining MEM_PROTOCOL_CHECK_EN.
module line_backing_memory #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
`ifdef MEM_PROTOCOL_CHECK_EN
    ,
    output logic         err_o
`endif
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                  state_reg, state_next;
    logic [7:0]              count_reg, count_next;
    logic [DEPTH_LOG2-1:0]   index_reg;
    logic                    write_reg;
    logic [255:0]            data_reg;
    logic [255:0]            data_o_reg;
    logic [255:0]            mem [DEPTH];
    logic                    accept;
    logic                    load_out;
    logic                    commit;
    logic                    unused_addr_bits;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        accept     = 1'b0;
        load_out   = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable_i) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                    count_next = LAT_M1;
                end
            end
            BUSY: begin
                if (count_reg == 8'd0) begin
                    state_next = ACK;
                    load_out   = 1'b1;
                end else begin
                    count_next = count_reg - 8'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
                commit     = write_reg;
            end
            default: state_next = IDLE;
        endcase
    end

    // A write presents its own data on data_o so the ack cycle always carries the line.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg  <= IDLE;
            count_reg  <= 8'd0;
            data_o_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (load_out) begin
                data_o_reg <= write_reg ? data_reg : mem[index_reg];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            index_reg <= addr_i[DEPTH_LOG2+4:5];
            write_reg <= write_i;
            data_reg  <= data_i;
        end
    end

    // Array has no reset; a reset in ACK suppresses the pending commit.
    always_ff @(posedge clk_i) begin
        if (commit && rst_i) begin
            mem[index_reg] <= data_reg;
        end
    end

    assign ack_o  = (state_reg == ACK);
    assign data_o = data_o_reg;

`ifdef MEM_PROTOCOL_CHECK_EN
    logic [26:0] addr_hi_reg;
    logic        err_reg;
    logic [7:0]  lane_diff;
    logic        mismatch;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_diff[gi] = (data_i[gi*32 +: 32] != data_reg[gi*32 +: 32]);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_hi_reg <= addr_i[31:5];
        end
    end

    assign mismatch = (state_reg == BUSY) &&
                      (!enable_i || (write_i != write_reg) ||
                       (addr_i[31:5] != addr_hi_reg) ||
                       (write_reg && (|lane_diff)));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            err_reg <= 1'b0;
        end else if (mismatch) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o            = err_reg;
    assign unused_addr_bits = ^addr_i[4:0];
`else
    assign unused_addr_bits = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};
`endif

endmodule
